// File: rtl/lfsr_parity_checker.sv
// Receive-side checker for the 8-bit parity/LFSR word stream: checks parity,
// locks a local 7-bit LFSR onto the stream, then flywheels and counts sequence errors.
//
// state  | meaning
// HUNT   | searching for a parity-clean, non-zero seed word
// VERIFY | seeded; counting consecutive matching words towards lock
// LOCKED | flywheeling the local LFSR, counting sequence mismatches
module lfsr_parity_checker #(
    parameter logic [6:0] TAPS       = 7'b1100000,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 3,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic [1:0]       sync_state,
    output logic [CNT_W-1:0] parity_err_cnt,
    output logic [CNT_W-1:0] seq_err_cnt,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [6:0] lfsr_next(input logic [6:0] q);
        return {q[5:0], ^(q & TAPS)};
    endfunction

    state_e           state_q, state_d;
    logic [6:0]       expected_q, expected_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             err_pulse_q, err_pulse_d;

    logic accept;
    logic par_ok;
    logic mismatch;

    assign accept   = ena & data_valid;
    assign par_ok   = (data_in[7] == ^data_in[6:0]);
    assign mismatch = (data_in[6:0] != expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_d     = match_q;
        miss_d      = miss_q;
        par_cnt_d   = par_cnt_q;
        seq_cnt_d   = seq_cnt_q;
        err_pulse_d = err_pulse_q;

        if (ena) begin
            err_pulse_d = accept & (!par_ok | ((state_q == LOCKED) & mismatch));

            case (state_q)
                HUNT: begin
                    if (accept && par_ok && (data_in[6:0] != 7'd0)) begin
                        expected_d = lfsr_next(data_in[6:0]);
                        match_d    = 4'd1;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (accept) begin
                        if (par_ok && !mismatch) begin
                            expected_d = lfsr_next(data_in[6:0]);
                            match_d    = match_q + 4'd1;
                            if ((match_q + 4'd1) == LOCK_C) begin
                                state_d = LOCKED;
                                miss_d  = 4'd0;
                            end
                        end else begin
                            // failing word is discarded, not used as a new seed
                            state_d = HUNT;
                            match_d = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        expected_d = lfsr_next(expected_q);
                        if (mismatch) begin
                            miss_d = miss_q + 4'd1;
                            if ((miss_q + 4'd1) == LOSS_C) begin
                                state_d = HUNT;
                                miss_d  = 4'd0;
                                match_d = 4'd0;
                            end
                        end else begin
                            miss_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase

            if (accept && !par_ok && (par_cnt_q != CNT_MAX))
                par_cnt_d = par_cnt_q + CNT_W'(1);
            if (accept && (state_q == LOCKED) && mismatch && (seq_cnt_q != CNT_MAX))
                seq_cnt_d = seq_cnt_q + CNT_W'(1);

            // clear has priority over a coincident increment
            if (clr_cnt) begin
                par_cnt_d = '0;
                seq_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            expected_q  <= 7'd0;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            par_cnt_q   <= '0;
            seq_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            par_cnt_q   <= par_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign sync_state     = state_q;
    assign locked         = (state_q == LOCKED);
    assign parity_err_cnt = par_cnt_q;
    assign seq_err_cnt    = seq_cnt_q;
    assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Directed bench for lfsr_parity_checker (CNT_W=4) with hand-computed expectations.
module tb_lfsr_parity_checker;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             clr_cnt;
    logic             locked;
    logic [1:0]       sync_state;
    logic [CNT_W-1:0] parity_err_cnt;
    logic [CNT_W-1:0] seq_err_cnt;
    logic             err_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_parity_checker #(
        .TAPS       (7'b1100000),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .clr_cnt        (clr_cnt),
        .locked         (locked),
        .sync_state     (sync_state),
        .parity_err_cnt (parity_err_cnt),
        .seq_err_cnt    (seq_err_cnt),
        .err_pulse      (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive one accepted word, sample 1 time unit after the capturing edge
    task automatic send(input logic [7:0] b, input logic clr = 1'b0, input logic en = 1'b1);
        @(negedge clk);
        ena        = en;
        data_in    = b;
        data_valid = 1'b1;
        clr_cnt    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        data_valid = 1'b0;
        clr_cnt    = 1'b0;
        ena        = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int st, input int lk,
                             input int pc, input int sc, input int ep);
        check({tag, ".state"},  int'(sync_state),     st);
        check({tag, ".locked"}, int'(locked),         lk);
        check({tag, ".par"},    int'(parity_err_cnt), pc);
        check({tag, ".seq"},    int'(seq_err_cnt),    sc);
        check({tag, ".pulse"},  int'(err_pulse),      ep);
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        clr_cnt    = 1'b0;

        // 1. reset before any clock edge, then idle
        #3;
        check_all("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check_all("idle", 0, 0, 0, 0, 0);

        // 2. clean lock on 01,02,04,08
        send(8'h81);
        check_all("lock_w1", 1, 0, 0, 0, 0);
        send(8'h82);
        send(8'h84);
        check("lock_w3.state", int'(sync_state), 1);
        send(8'h88);
        check_all("lock_w4", 2, 1, 0, 0, 0);

        // 3. 0x10 with wrong parity in place of 0x90: value matches, parity error only
        send(8'h10);
        check_all("par_locked", 2, 1, 1, 0, 1);
        send(8'hA0);
        check_all("par_pulse_end", 2, 1, 1, 0, 0);
        send(8'h41);
        check_all("par_after", 2, 1, 1, 0, 0);

        // 4. drop 0x03: 06,0C,18 arrive against expected 03,06,0C
        send(8'h06);
        check_all("drop1", 2, 1, 1, 1, 1);
        send(8'h0C);
        check_all("drop2", 2, 1, 1, 2, 1);
        send(8'h18);
        check_all("drop3", 0, 0, 1, 3, 1);
        send(8'h30);
        check_all("relock1", 1, 0, 1, 3, 0);
        send(8'hE1);
        send(8'h42);
        send(8'h05);
        check_all("relock4", 2, 1, 1, 3, 0);

        // 5. 20 bad-parity zero words: 3 seq errors then HUNT; parity count saturates
        for (int i = 0; i < 20; i++) begin
            send(8'h80);
            if (i == 2) check("sat_drop.state", int'(sync_state), 0);
        end
        check_all("sat", 0, 0, 15, 6, 1);
        send(8'h80, 1'b1);
        check_all("clr_wins", 0, 0, 0, 0, 1);

        // VERIFY failure returns to HUNT without counting sequence errors
        send(8'h81);
        check("verify.state", int'(sync_state), 1);
        send(8'h84);
        check_all("verify_fail", 0, 0, 0, 0, 0);

        // 6. relock, hold with ena=0, then asynchronous reset while locked
        send(8'h81);
        send(8'h82);
        send(8'h84);
        send(8'h88);
        check("relock2.locked", int'(locked), 1);
        for (int i = 0; i < 3; i++) send(8'h80, 1'b1, 1'b0);
        check_all("hold", 2, 1, 0, 0, 0);
        send(8'h10);
        check_all("pre_rst", 2, 1, 1, 0, 1);
        data_valid = 1'b0;
        rst_n      = 1'b0;
        #2;
        check_all("async_rst", 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        idle(2);
        check_all("post_rst", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
